force_accumulator: RTL and testbench
====================================

// Module: force_accumulator
// PURPOSE
//  Sits directly downstream of the compute pipeline; consumes its per-pair reference/neighbour force outputs.
//  Read-modify-writes each force into a register-file force cache indexed by particle slot (two updates/cycle).
//  On pipeline done, drains the cache in slot order over a valid/ready stream, then clears it for the next cell pass.
// PARAMETERS
//  DEPTH   64  force-cache entries (particle slots per cell neighbourhood)
//  ADDR_W  6   slot index width, = clog2(DEPTH)
//  W       32  width of one force component, signed two's complement fixed point
// PORTS
//  clk           in   1        clock, all logic on rising edge
//  reset         in   1        asynchronous, active-low reset
//  ref_force     in   3*W+1    {valid[96], fz[95:64], fy[63:32], fx[31:0]}, force on the reference particle
//  ref_addr      in   ADDR_W   cache slot of the reference particle
//  nbr_force     in   3*W+1    same format, force on the neighbour particle (already negated upstream)
//  nbr_addr      in   ADDR_W   cache slot of the neighbour particle
//  pipeline_done in   1        level; upstream pipeline has finished the pass
//  out_valid     out  1        drain word valid
//  out_ready     in   1        drain consumer accepts
//  out_addr      out  ADDR_W   slot of the drain word
//  out_force     out  3*W      {fz, fy, fx} accumulated total
//  out_last      out  1        high with the word for slot DEPTH-1
//  busy          out  1        high in DRAIN and WAIT_REL
//  ovr_err       out  1        sticky; a valid input arrived outside ACCUM
// BEHAVIOUR
//  Reset
//   - state=ACCUM, all cache entries 0, drain ptr 0.
//   - out_valid, out_last, busy, ovr_err = 0; out_addr, out_force = 0.
//   - Reset mid-drain aborts the drain and zeroes the cache; no partial output survives.
//  FSM: ACCUM -> DRAIN -> WAIT_REL -> ACCUM
//  ACCUM
//   - Each cycle, ref_force[96]=1: cache[ref_addr] += ref components.
//   - Same cycle, nbr_force[96]=1: cache[nbr_addr] += nbr components.
//   - Both valid with ref_addr==nbr_addr: entry <= sat(entry + ref + nbr), one saturation in W+2 bits.
//   - Invalid input (bit 96=0): ignored, its addr is don't-care.
//   - Update is visible next cycle. Back-to-back hits on one slot must accumulate with no lost update.
//   - Sampled pipeline_done=1: forces with valid in that same cycle are still accumulated; next state DRAIN, ptr=0.
//  Saturation
//   - Per component, independent: clamp to +2^(W-1)-1 / -2^(W-1).
//   - Never wraps. Saturated value is kept and accumulation continues from it.
//  DRAIN
//   - out_valid=1, out_addr=ptr, out_force=cache[ptr] (registered, stable until accepted).
//   - out_valid & out_ready: cache[ptr]<=0, ptr++; next word presented the following cycle, 1 word/cycle max.
//   - out_last=1 only while ptr==DEPTH-1. Acceptance of that word -> WAIT_REL, out_valid=0.
//   - out_ready low stalls indefinitely with outputs held.
//  WAIT_REL
//   - Waits for pipeline_done=0, then ACCUM. Prevents re-drain on a held done level.
//  Inputs in DRAIN/WAIT_REL
//   - Not accumulated; any valid bit sets ovr_err (cleared only by reset).
//  Latency
//   - pipeline_done sampled -> first out_valid: 1 cycle.
//   - Full drain: DEPTH cycles with out_ready tied high.
// TESTING
//  1 Reset: hold reset=0 with random inputs -> all outputs 0; release, pipeline_done=1, ready=1 -> 64 words, all force 0, last on addr 63.
//  2 Single hits: ref fx=5 @slot3, nbr fx=-5 @slot7, one cycle; drain -> slot3 fx=5, slot7 fx=-5, others 0.
//  3 Collision + back-to-back: ref fy=2 and nbr fy=3 @slot9 for 4 consecutive cycles -> slot9 fy=20.
//  4 Saturation: 2x ref fx=0x7FFF_0000 @slot1 -> fx=0x7FFF_FFFF; then ref fx=-1 -> 0x7FFF_FFFE; fz=-2^31 stays 0x8000_0000 under negative input.
//  5 Backpressure: out_ready toggles 1,0,0,1 during drain -> words in order 0..63, none dropped/duplicated, out_force stable while stalled.
//  6 Pass hygiene: pipeline_done held 1 after drain; valid ref in WAIT_REL -> ovr_err=1, no second drain; done=0 then new pass -> drain shows only new-pass sums.

Source files
------------

// File: rtl/force_accumulator_if.sv
// Upstream force inputs and the drain stream of the force accumulator.
// master = pipeline/drain-consumer side, slave = accumulator side.
interface force_accumulator_if #(
    parameter int W      = 32,
    parameter int ADDR_W = 6
);
    logic [3*W:0]      ref_force;
    logic [ADDR_W-1:0] ref_addr;
    logic [3*W:0]      nbr_force;
    logic [ADDR_W-1:0] nbr_addr;
    logic              pipeline_done;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [3*W-1:0]    out_force;
    logic              out_last;
    logic              busy;
    logic              ovr_err;

    modport master (
        output ref_force, ref_addr, nbr_force, nbr_addr, pipeline_done, out_ready,
        input  out_valid, out_addr, out_force, out_last, busy, ovr_err
    );

    modport slave (
        input  ref_force, ref_addr, nbr_force, nbr_addr, pipeline_done, out_ready,
        output out_valid, out_addr, out_force, out_last, busy, ovr_err
    );
endinterface

// File: rtl/force_accumulator.sv
// Saturating per-slot force cache: two read-modify-write updates per cycle while
// accumulating, then an in-order valid/ready drain that clears each slot as it goes.
module force_accumulator #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int W      = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    force_accumulator_if.slave  bus
);
    typedef enum logic [1:0] {ACCUM, DRAIN, WAIT_REL} state_e;
    typedef logic [2:0][W-1:0] vec3_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e                 state_q;
    logic [ADDR_W-1:0]      ptr_q;
    vec3_t [DEPTH-1:0]      cache_q, cache_d;
    vec3_t                  out_force_q;
    logic                   out_valid_q, out_last_q, busy_q, ovr_err_q;

    logic                   ref_v, nbr_v, collide, accept;
    vec3_t                  ref_f, nbr_f;
    logic [ADDR_W-1:0]      ptr_nxt;

    assign ref_v   = bus.ref_force[3*W];
    assign nbr_v   = bus.nbr_force[3*W];
    assign ref_f   = bus.ref_force[3*W-1:0];
    assign nbr_f   = bus.nbr_force[3*W-1:0];
    // Same-slot hits are merged so the entry takes a single saturation.
    assign collide = ref_v & nbr_v & (bus.ref_addr == bus.nbr_addr);
    assign accept  = out_valid_q & bus.out_ready;
    assign ptr_nxt = ptr_q + ADDR_W'(1);

    // Three-operand add in W+2 bits, clamped back to W bits.
    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c);
        logic [W+1:0] s;
        s = {{2{a[W-1]}}, a} + {{2{b[W-1]}}, b} + {{2{c[W-1]}}, c};
        if (s[W+1:W-1] == 3'b000 || s[W+1:W-1] == 3'b111)
            sat_add = s[W-1:0];
        else if (s[W+1])
            sat_add = {1'b1, {(W-1){1'b0}}};
        else
            sat_add = {1'b0, {(W-1){1'b1}}};
    endfunction

    always_comb begin
        cache_d = cache_q;
        if (state_q == ACCUM) begin
            for (int c = 0; c < 3; c++) begin
                if (ref_v)
                    cache_d[bus.ref_addr][c] = sat_add(cache_q[bus.ref_addr][c], ref_f[c],
                                                       collide ? nbr_f[c] : '0);
                if (nbr_v && !collide)
                    cache_d[bus.nbr_addr][c] = sat_add(cache_q[bus.nbr_addr][c], nbr_f[c], '0);
            end
        end else if (accept) begin
            cache_d[ptr_q] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            ptr_q       <= '0;
            cache_q     <= '0;
            out_force_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            ovr_err_q   <= 1'b0;
        end else begin
            cache_q <= cache_d;
            if (state_q != ACCUM && (ref_v || nbr_v))
                ovr_err_q <= 1'b1;
            case (state_q)
                ACCUM: begin
                    // The done cycle's own updates must be in the first word, hence cache_d.
                    if (bus.pipeline_done) begin
                        state_q     <= DRAIN;
                        ptr_q       <= '0;
                        out_valid_q <= 1'b1;
                        out_force_q <= cache_d[0];
                        out_last_q  <= (LAST == '0);
                        busy_q      <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        if (ptr_q == LAST) begin
                            state_q     <= WAIT_REL;
                            ptr_q       <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_force_q <= '0;
                        end else begin
                            ptr_q       <= ptr_nxt;
                            out_force_q <= cache_q[ptr_nxt];
                            out_last_q  <= (ptr_nxt == LAST);
                        end
                    end
                end
                WAIT_REL: begin
                    if (!bus.pipeline_done) begin
                        state_q <= ACCUM;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = ptr_q;
    assign bus.out_force = out_force_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.ovr_err   = ovr_err_q;

    a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid_q && !bus.out_ready |=> out_valid_q && $stable(out_force_q) && $stable(ptr_q));
    a_last_slot: assert property (@(posedge clk) disable iff (!rst_n)
        out_last_q |-> out_valid_q && ptr_q == LAST);
    a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
        busy_q == (state_q != ACCUM));
endmodule

// File: tb/tb_force_accumulator.sv
// Directed table passes, hand-written corner sequences and random passes against a slot-array model.
module tb_force_accumulator;
    localparam int W = 32, AW = 6, DEPTH = 64;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    force_accumulator_if #(.W(W), .ADDR_W(AW)) ifc ();
    force_accumulator #(.DEPTH(DEPTH), .ADDR_W(AW), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc.slave)
    );

    typedef struct {
        bit rv; int ra; int rx, ry, rz;
        bit nv; int na; int nx, ny, nz;
        int reps;
        int sa; int ax, ay, az;
        int sb; int bx, by, bz;
    } vec_t;

    int             tests = 0, fails = 0;
    longint         mdl [DEPTH][3];
    logic [3*W-1:0] exp_mem [DEPTH];
    vec_t           tbl [5];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint clamp(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    task automatic drive(input bit rv, input int ra, input int rx, input int ry, input int rz,
                         input bit nv, input int na, input int nx, input int ny, input int nz,
                         input bit done);
        ifc.ref_force     = {rv, rz, ry, rx};
        ifc.ref_addr      = AW'(ra);
        ifc.nbr_force     = {nv, nz, ny, nx};
        ifc.nbr_addr      = AW'(na);
        ifc.pipeline_done = done;
    endtask

    // One accumulate cycle: drive, fold into the model, clock.
    task automatic cycle(input bit rv, input int ra, input int rx, input int ry, input int rz,
                         input bit nv, input int na, input int nx, input int ny, input int nz,
                         input bit done);
        int r[3], n[3];
        r = '{rx, ry, rz};
        n = '{nx, ny, nz};
        drive(rv, ra, rx, ry, rz, nv, na, nx, ny, nz, done);
        if (rv && nv && ra == na) begin
            for (int c = 0; c < 3; c++) mdl[ra][c] = clamp(mdl[ra][c] + longint'(r[c]) + longint'(n[c]));
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (rv) mdl[ra][c] = clamp(mdl[ra][c] + longint'(r[c]));
                if (nv) mdl[na][c] = clamp(mdl[na][c] + longint'(n[c]));
            end
        end
        tick();
    endtask

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) for (int c = 0; c < 3; c++) mdl[i][c] = 0;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    endtask

    task automatic load_exp_from_model();
        longint t;
        for (int i = 0; i < DEPTH; i++)
            for (int c = 0; c < 3; c++) begin
                t = mdl[i][c];
                exp_mem[i][c*32 +: 32] = t[31:0];
            end
        zero_model();
    endtask

    // Called right after the edge that sampled pipeline_done in ACCUM.
    // mode 0: ready high, 1: ready 1,0,0,1 repeating, 2: random ready.
    task automatic drain(input int mode, input bit hold_done);
        logic [127:0] cur, prev;
        bit stalled = 0, rdy;
        int ptr = 0, cyc = 0;
        prev = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, hold_done);
        while (ptr < DEPTH && cyc < 1000) begin
            cur = {ifc.out_valid, ifc.out_last, ifc.busy, ifc.out_addr, ifc.out_force};
            chk("drain_word", cur, {1'b1, ptr == DEPTH-1, 1'b1, AW'(ptr), exp_mem[ptr]});
            if (stalled) chk("stall_hold", cur, prev);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            ifc.out_ready = rdy;
            prev = cur;
            stalled = !rdy;
            tick();
            cyc++;
            if (rdy) ptr++;
        end
        ifc.out_ready = 1'b0;
        chk("drain_count", 128'(ptr), 128'(DEPTH));
        if (mode == 0) chk("drain_cycles", 128'(cyc), 128'(DEPTH));
        chk("post_drain", {ifc.out_valid, ifc.busy}, 2'b01);
    endtask

    task automatic release_done();
        ifc.pipeline_done = 1'b0;
        tick();
        chk("release", {ifc.busy, ifc.out_valid}, 2'b00);
    endtask

    initial begin
        tbl[0] = '{1, 3, 5, 0, 0,  1, 7, -5, 0, 0,  1,  3, 5, 0, 0,  7, -5, 0, 0};
        tbl[1] = '{1, 9, 0, 2, 0,  1, 9, 0, 3, 0,   4,  9, 0, 20, 0, 9, 0, 20, 0};
        tbl[2] = '{1, 2, 32'h7FFFFFFF, 0, 0,  1, 2, -1, 0, 0,  2,
                   2, 32'h7FFFFFFF, 0, 0,  2, 32'h7FFFFFFF, 0, 0};
        tbl[3] = '{1, 0, 100, -200, 300,  1, 63, -1, -2, -3,  3,
                   0, 300, -600, 900,  63, -3, -6, -9};
        tbl[4] = '{1, 5, 0, 0, 32'h80000000,  1, 5, 0, 0, -7,  2,
                   5, 0, 0, 32'h80000000,  5, 0, 0, 32'h80000000};

        zero_model();
        ifc.out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset held with random inputs: outputs stay zero.
        for (int k = 0; k < 5; k++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 63), int'($urandom), int'($urandom), int'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 63), int'($urandom), int'($urandom), int'($urandom),
                  1'($urandom_range(0, 1)));
            ifc.out_ready = 1'($urandom_range(0, 1));
            tick();
            chk("reset_outputs", {ifc.out_valid, ifc.out_last, ifc.busy, ifc.ovr_err, ifc.out_addr, ifc.out_force}, '0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        ifc.out_ready = 1'b0;
        rst_n = 1'b1;
        tick();
        clear_exp();
        drain(0, 0);
        release_done();

        // Table-driven passes: one input pattern repeated, then a full drain.
        for (int t = 0; t < 5; t++) begin
            for (int r = 0; r < tbl[t].reps; r++)
                cycle(tbl[t].rv, tbl[t].ra, tbl[t].rx, tbl[t].ry, tbl[t].rz,
                      tbl[t].nv, tbl[t].na, tbl[t].nx, tbl[t].ny, tbl[t].nz, r == tbl[t].reps - 1);
            zero_model();
            clear_exp();
            exp_mem[tbl[t].sa] = {tbl[t].az, tbl[t].ay, tbl[t].ax};
            exp_mem[tbl[t].sb] = {tbl[t].bz, tbl[t].by, tbl[t].bx};
            drain(t % 2, 0);
            release_done();
        end

        // Saturation is sticky but not frozen: accumulation resumes from the clamp.
        cycle(1, 1, 32'h7FFF0000, 0, 0,  1, 4, 0, 0, 32'h80000000, 0);
        cycle(1, 1, 32'h7FFF0000, 0, 0,  1, 4, 0, 0, 32'h80000000, 0);
        cycle(1, 1, -1, 0, 0,            1, 4, 0, 0, -5, 1);
        zero_model();
        clear_exp();
        exp_mem[1] = {32'h0, 32'h0, 32'h7FFFFFFE};
        exp_mem[4] = {32'h80000000, 32'h0, 32'h0};
        drain(1, 0);
        release_done();
        chk("ovr_clean", ifc.ovr_err, 1'b0);

        // Held done after drain: no re-drain, late input flagged and dropped.
        cycle(1, 20, 11, 0, 0,  0, 0, 0, 0, 0,  1);
        load_exp_from_model();
        drain(0, 1);
        drive(1, 20, 999, 0, 0,  0, 0, 0, 0, 0,  1);
        tick();
        chk("wait_rel_ovr", {ifc.out_valid, ifc.busy, ifc.ovr_err}, 3'b011);
        drive(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("no_redrain", {ifc.out_valid, ifc.busy, ifc.ovr_err}, 3'b011);
        end
        release_done();
        chk("ovr_sticky", ifc.ovr_err, 1'b1);
        cycle(0, 0, 0, 0, 0,    1, 21, 0, 7, 0,  0);
        cycle(1, 20, 0, 0, -3,  0, 0, 0, 0, 0,   1);
        load_exp_from_model();
        drain(2, 0);
        release_done();

        // Reset mid-drain wipes the cache and the partial drain.
        cycle(1, 0, 42, 0, 0,  1, 1, 43, 0, 0,  1);
        ifc.out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        ifc.out_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #2;
        chk("reset_mid_drain", {ifc.out_valid, ifc.out_last, ifc.busy, ifc.ovr_err, ifc.out_addr, ifc.out_force}, '0);
        tick();
        rst_n = 1'b1;
        zero_model();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        clear_exp();
        drain(0, 0);
        release_done();

        // Random passes against the model.
        for (int p = 0; p < 6; p++) begin
            int n;
            n = $urandom_range(20, 50);
            for (int k = 0; k < n; k++) begin
                int v[6];
                int ra, na;
                for (int j = 0; j < 6; j++) begin
                    case ($urandom_range(0, 3))
                        0:       v[j] = int'($urandom);
                        1:       v[j] = int'($urandom_range(0, 200)) - 100;
                        2:       v[j] = 0;
                        default: v[j] = $urandom_range(0, 1) ? 32'h7FFFFFF0 : 32'h80000010;
                    endcase
                end
                ra = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 63);
                na = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 63);
                cycle(1'($urandom_range(0, 1)), ra, v[0], v[1], v[2],
                      1'($urandom_range(0, 1)), na, v[3], v[4], v[5], k == n - 1);
            end
            load_exp_from_model();
            drain((p % 2 == 0) ? 2 : 1, 0);
            release_done();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
